// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
// The control patterns below are the only legal en/flush combinations the controller produces.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RESET    = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                        exmem_en: 1'b0, memwb_en: 1'b0, ifid_flush: 1'b1,
                                        idex_flush: 1'b1, memwb_flush: 1'b1};

    localparam pipe_ctl_t CTL_ADVANCE = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                          exmem_en: 1'b1, memwb_en: 1'b1, ifid_flush: 1'b0,
                                          idex_flush: 1'b0, memwb_flush: 1'b0};

    // Wrong-path squash: everything advances, the two younger instructions become bubbles.
    localparam pipe_ctl_t CTL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                         exmem_en: 1'b1, memwb_en: 1'b1, ifid_flush: 1'b1,
                                         idex_flush: 1'b1, memwb_flush: 1'b0};

    localparam pipe_ctl_t CTL_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1,
                                           exmem_en: 1'b1, memwb_en: 1'b1, ifid_flush: 1'b0,
                                           idex_flush: 1'b1, memwb_flush: 1'b0};

    // Frozen pipeline: nothing moves, WB sees a bubble so a stalled load is not retired twice.
    localparam pipe_ctl_t CTL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                         exmem_en: 1'b0, memwb_en: 1'b0, ifid_flush: 1'b0,
                                         idex_flush: 1'b0, memwb_flush: 1'b1};

    localparam pipe_ctl_t CTL_HALT = '{default: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control/status bundle between the pipeline datapath and the sequencing controller.
// master = datapath side, slave = controller side.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_num;
    logic [4:0]       id_rt_num;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_mem_to_reg;
    logic             ex_reg_write;
    logic [4:0]       ex_rd_num;
    logic             ex_branch;
    logic             ex_zero;
    logic             mem_access;
    logic             dmem_ready;

    logic             dmem_req;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs_num, id_rt_num, id_uses_rs, id_uses_rt,
               ex_mem_to_reg, ex_reg_write, ex_rd_num, ex_branch, ex_zero,
               mem_access, dmem_ready,
        input  dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, halted, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs_num, id_rt_num, id_uses_rs, id_uses_rt,
               ex_mem_to_reg, ex_reg_write, ex_rd_num, ex_branch, ex_zero,
               mem_access, dmem_ready,
        output dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, halted, stall_cycles, flush_events
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the instruction in ID and a load in EX.
// Kept standalone so the forwarding unit can share the same register-match logic.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs_num,
    input  logic [4:0] i_id_rt_num,
    input  logic       i_id_uses_rs,
    input  logic       i_id_uses_rt,
    input  logic       i_ex_mem_to_reg,
    input  logic       i_ex_reg_write,
    input  logic [4:0] i_ex_rd_num,
    output logic       o_load_use
);

    logic w_ex_load;
    logic w_rs_match;
    logic w_rt_match;

    // r0 is hardwired to zero, so a load targeting it never produces a value to wait for.
    assign w_ex_load  = i_ex_mem_to_reg & i_ex_reg_write & (i_ex_rd_num != REG_ZERO);
    assign w_rs_match = i_id_uses_rs & (i_id_rs_num == i_ex_rd_num);
    assign w_rt_match = i_id_uses_rt & (i_id_rt_num == i_ex_rd_num);
    assign o_load_use = w_ex_load & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch squash, data-memory freeze,
// memory timeout halt and saturating performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_halted;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic [CNT_W-1:0]   r_flush_events;

    logic               w_taken;
    logic               w_mem_stall;
    logic               w_load_use;
    pipe_ctl_t          w_resume_ctl;
    logic               w_resume_stall;
    logic               w_resume_flush;
    pipe_ctl_t          w_ctl;
    logic               w_dmem_req;
    logic               w_stall_inc;
    logic               w_flush_inc;

    hazard_detect u_hazard_detect (
        .i_id_rs_num     (bus.id_rs_num),
        .i_id_rt_num     (bus.id_rt_num),
        .i_id_uses_rs    (bus.id_uses_rs),
        .i_id_uses_rt    (bus.id_uses_rt),
        .i_ex_mem_to_reg (bus.ex_mem_to_reg),
        .i_ex_reg_write  (bus.ex_reg_write),
        .i_ex_rd_num     (bus.ex_rd_num),
        .o_load_use      (w_load_use)
    );

    assign w_taken     = bus.ex_branch & bus.ex_zero;
    assign w_mem_stall = bus.mem_access & ~bus.dmem_ready;

    // Behaviour of a cycle in which memory is not holding the pipeline back.
    // A taken branch wins over load-use because the dependent ID instruction is squashed anyway.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_resume_ctl   = CTL_ADVANCE;
        w_resume_stall = 1'b0;
        w_resume_flush = 1'b0;
        if (w_taken) begin
            w_resume_ctl   = CTL_BRANCH;
            w_resume_flush = 1'b1;
        end else if (w_load_use) begin
            w_resume_ctl   = CTL_LOAD_USE;
            w_resume_stall = 1'b1;
        end
    end

    always_comb begin
        w_ctl       = CTL_HALT;
        w_dmem_req  = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        case (r_state)
            S_RESET: w_ctl = CTL_RESET;
            S_RUN: begin
                w_dmem_req = bus.mem_access;
                if (w_mem_stall) begin
                    w_ctl       = CTL_FREEZE;
                    w_stall_inc = 1'b1;
                end else begin
                    w_ctl       = w_resume_ctl;
                    w_stall_inc = w_resume_stall;
                    w_flush_inc = w_resume_flush;
                end
            end
            S_MEM_WAIT: begin
                w_dmem_req = 1'b1;
                if (bus.dmem_ready) begin
                    w_ctl       = w_resume_ctl;
                    w_stall_inc = w_resume_stall;
                    w_flush_inc = w_resume_flush;
                end else begin
                    w_ctl       = CTL_FREEZE;
                    w_stall_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RESET;
            r_wait_cnt <= '0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_RUN;
                S_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        if (r_wait_cnt == WAIT_LAST) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                    end
                end
                S_HALT:  r_halted <= 1'b1;
                default: r_state  <= S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign bus.dmem_req     = w_dmem_req;
    assign bus.pc_en        = w_ctl.pc_en;
    assign bus.ifid_en      = w_ctl.ifid_en;
    assign bus.idex_en      = w_ctl.idex_en;
    assign bus.exmem_en     = w_ctl.exmem_en;
    assign bus.memwb_en     = w_ctl.memwb_en;
    assign bus.ifid_flush   = w_ctl.ifid_flush;
    assign bus.idex_flush   = w_ctl.idex_flush;
    assign bus.memwb_flush  = w_ctl.memwb_flush;
    assign bus.halted       = r_halted;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes the expected per-cycle response,
// a negedge monitor pops and compares it against the live outputs.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, memwb_fl, dmem_req, halted}
    localparam logic [9:0] E_RESET = 10'b00000_111_0_0;
    localparam logic [9:0] E_RUN   = 10'b11111_000_0_0;
    localparam logic [9:0] E_RUNQ  = 10'b11111_000_1_0;
    localparam logic [9:0] E_LU    = 10'b00111_010_0_0;
    localparam logic [9:0] E_LUQ   = 10'b00111_010_1_0;
    localparam logic [9:0] E_BR    = 10'b11111_110_0_0;
    localparam logic [9:0] E_FRZ   = 10'b00000_001_1_0;
    localparam logic [9:0] E_HALT  = 10'b00000_000_0_1;

    typedef struct {
        string      tag;
        logic [9:0] ctl;
        int         stall;
        int         flush;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [9:0] ctl, input int stall, input int flush);
        exp_t e;
        e.tag   = tag;
        e.ctl   = ctl;
        e.stall = stall;
        e.flush = flush;
        q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                         input logic m2r, input logic rw, input logic [4:0] rd,
                         input logic br, input logic zr, input logic ma, input logic rdy);
        bus.id_rs_num     = rs;
        bus.id_rt_num     = rt;
        bus.id_uses_rs    = urs;
        bus.id_uses_rt    = urt;
        bus.ex_mem_to_reg = m2r;
        bus.ex_reg_write  = rw;
        bus.ex_rd_num     = rd;
        bus.ex_branch     = br;
        bus.ex_zero       = zr;
        bus.mem_access    = ma;
        bus.dmem_ready    = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: the controller presents a response every cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [9:0] act;
            e   = q.pop_front();
            act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                   bus.ifid_flush, bus.idex_flush, bus.memwb_flush, bus.dmem_req, bus.halted};
            check({e.tag, ".ctl"},   32'(act),              32'(e.ctl));
            check({e.tag, ".stall"}, 32'(bus.stall_cycles), 32'(e.stall));
            check({e.tag, ".flush"}, 32'(bus.flush_events), 32'(e.flush));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        tick(); push_exp("rst_hold", E_RESET, 0, 0);
        tick(); rst_n = 1'b1; push_exp("rst_release", E_RESET, 0, 0);
        tick(); push_exp("run_first", E_RUN, 0, 0);

        // Load-use via rt, then r0, unused-source and non-writing-load exemptions.
        tick(); drive(5'd3, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("load_use_rt", E_LU, 0, 0);
        tick(); idle(); push_exp("load_use_after", E_RUN, 1, 0);
        tick(); drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("r0_exempt", E_RUN, 1, 0);
        tick(); drive(5'd9, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("rs_unused", E_RUN, 1, 0);
        tick(); drive(5'd9, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("load_no_write", E_RUN, 1, 0);

        // Taken branch beats a simultaneous load-use (rs match); untaken branch is transparent.
        tick(); drive(5'd8, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp("branch_vs_lu", E_BR, 1, 0);
        tick(); idle(); push_exp("branch_after", E_RUN, 1, 1);
        tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("branch_not_taken", E_RUN, 1, 1);

        // Zero-wait access, then three wait cycles before ready.
        tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        push_exp("mem_zero_wait", E_RUNQ, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            push_exp("mem_wait", E_FRZ, 1 + i, 1);
        end
        tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        push_exp("mem_done", E_RUNQ, 4, 1);
        tick(); idle(); push_exp("mem_after", E_RUN, 4, 1);

        // Access completes in MEM_WAIT together with a load-use hazard.
        tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_exp("mw_lu_wait", E_FRZ, 4, 1);
        tick(); drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        push_exp("mw_lu_resume", E_LUQ, 5, 1);
        tick(); idle(); push_exp("mw_lu_after", E_RUN, 6, 1);

        // Saturation of the 4-bit stall counter at 15.
        for (int i = 0; i < 12; i++) begin
            tick(); drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
            push_exp("stall_sat", E_LU, (6 + i > 15) ? 15 : 6 + i, 1);
        end
        tick(); idle(); push_exp("stall_sat_hold", E_RUN, 15, 1);

        // Reset asserted mid-cycle during an access drops everything at once.
        tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2; rst_n = 1'b0; push_exp("rst_mid_access", E_RESET, 0, 0);
        tick(); rst_n = 1'b1; idle(); push_exp("rst_mid_release", E_RESET, 0, 0);
        tick(); push_exp("rst_mid_run", E_RUN, 0, 0);

        // Timeout: four unanswered wait cycles enter HALT, ready afterwards is ignored.
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            push_exp("timeout_wait", E_FRZ, i, 0);
        end
        tick(); push_exp("halt_entered", E_HALT, 4, 0);
        tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        push_exp("halt_sticky", E_HALT, 4, 0);
        tick(); rst_n = 1'b0; idle(); push_exp("halt_reset", E_RESET, 0, 0);
        tick(); rst_n = 1'b1; push_exp("halt_release", E_RESET, 0, 0);
        tick(); push_exp("halt_recovered", E_RUN, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
